// File: rtl/psg_bus_scheduler.sv
// Arbitrates CPU register accesses and a buffered player write stream onto one
// PSG bus, skipping the address-latch phase when the register is already latched.
module psg_bus_scheduler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CPU_REQ,
  input  logic       CPU_WR,
  input  logic [3:0] CPU_ADDR,
  input  logic [7:0] CPU_DI,
  output logic       CPU_ACK,
  output logic [7:0] CPU_DO,
  input  logic       PLY_VALID,
  output logic       PLY_READY,
  input  logic [3:0] PLY_ADDR,
  input  logic [7:0] PLY_DATA,
  output logic       PSG_BDIR,
  output logic       PSG_BC,
  output logic [7:0] PSG_DI,
  input  logic [7:0] PSG_DO,
  output logic       BUSY,
  output logic [4:0] FIFO_LEVEL
);

  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  state_t        state_r;
  logic [11:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [4:0]    level_r;
  logic [3:0]    cur_addr_r;
  logic [7:0]    cur_data_r;
  logic          cur_rd_r;
  logic          cur_cpu_r;
  logic [3:0]    last_addr_r;
  logic          last_valid_r;
  logic          bdir_r;
  logic          bc_r;
  logic [7:0]    psg_di_r;
  logic          cpu_ack_r;
  logic [7:0]    cpu_do_r;

  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic [11:0]   head_s;
  logic          gnt_ply_s;
  logic          gnt_cpu_s;
  logic          gnt_rd_s;
  logic [3:0]    gnt_addr_s;
  logic [7:0]    gnt_data_s;
  logic          need_latch_s;

  assign full_s  = (level_r == DEPTH_L);
  assign empty_s = (level_r == 5'd0);
  assign push_s  = PLY_VALID && !full_s;
  assign head_s  = mem_r[rd_ptr_r];

  // Requester selection; the CPU is held off during its own ACK cycle
  always_comb begin
    gnt_ply_s = 1'b0;
    gnt_cpu_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (full_s) begin
        gnt_ply_s = 1'b1;
      end else if (CPU_REQ && !cpu_ack_r) begin
        gnt_cpu_s = 1'b1;
      end else if (!empty_s) begin
        gnt_ply_s = 1'b1;
      end else begin
        gnt_ply_s = 1'b0;
      end
    end else begin
      gnt_ply_s = 1'b0;
    end
  end

  // Transaction fields of whichever requester is granted
  always_comb begin
    if (gnt_ply_s) begin
      gnt_addr_s = head_s[11:8];
      gnt_data_s = head_s[7:0];
      gnt_rd_s   = 1'b0;
    end else begin
      gnt_addr_s = CPU_ADDR;
      gnt_data_s = CPU_DI;
      gnt_rd_s   = !CPU_WR;
    end
    need_latch_s = !last_valid_r || (gnt_addr_s != last_addr_r);
  end

  // FIFO storage
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {PLY_ADDR, PLY_DATA};
    end
  end

  // FIFO pointers and occupancy; the head pops in the player grant cycle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= 5'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (gnt_ply_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, gnt_ply_s})
        2'b10:   level_r <= level_r + 5'd1;
        2'b01:   level_r <= level_r - 5'd1;
        default: level_r <= level_r;
      endcase
    end
  end

  // Bus FSM; bus outputs are loaded with the values of the state being entered
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= ST_IDLE;
      cur_addr_r   <= 4'h0;
      cur_data_r   <= 8'h00;
      cur_rd_r     <= 1'b0;
      cur_cpu_r    <= 1'b0;
      last_addr_r  <= 4'h0;
      last_valid_r <= 1'b0;
      bdir_r       <= 1'b0;
      bc_r         <= 1'b0;
      psg_di_r     <= 8'h00;
      cpu_ack_r    <= 1'b0;
      cpu_do_r     <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cpu_ack_r <= 1'b0;
          if (gnt_ply_s || gnt_cpu_s) begin
            cur_addr_r <= gnt_addr_s;
            cur_data_r <= gnt_data_s;
            cur_rd_r   <= gnt_rd_s;
            cur_cpu_r  <= gnt_cpu_s;
            if (need_latch_s) begin
              state_r  <= ST_LATCH;
              bdir_r   <= 1'b1;
              bc_r     <= 1'b1;
              psg_di_r <= {4'h0, gnt_addr_s};
            end else if (gnt_rd_s) begin
              state_r  <= ST_READ;
              bdir_r   <= 1'b0;
              bc_r     <= 1'b1;
              psg_di_r <= 8'h00;
            end else begin
              state_r  <= ST_WRITE;
              bdir_r   <= 1'b1;
              bc_r     <= 1'b0;
              psg_di_r <= gnt_data_s;
            end
          end else begin
            state_r  <= ST_IDLE;
            bdir_r   <= 1'b0;
            bc_r     <= 1'b0;
            psg_di_r <= 8'h00;
          end
        end
        ST_LATCH: begin
          last_addr_r  <= cur_addr_r;
          last_valid_r <= 1'b1;
          if (cur_rd_r) begin
            state_r  <= ST_READ;
            bdir_r   <= 1'b0;
            bc_r     <= 1'b1;
            psg_di_r <= 8'h00;
          end else begin
            state_r  <= ST_WRITE;
            bdir_r   <= 1'b1;
            bc_r     <= 1'b0;
            psg_di_r <= cur_data_r;
          end
        end
        ST_WRITE: begin
          state_r   <= ST_IDLE;
          bdir_r    <= 1'b0;
          bc_r      <= 1'b0;
          psg_di_r  <= 8'h00;
          cpu_ack_r <= cur_cpu_r;
        end
        ST_READ: begin
          state_r   <= ST_IDLE;
          bdir_r    <= 1'b0;
          bc_r      <= 1'b0;
          psg_di_r  <= 8'h00;
          cpu_ack_r <= cur_cpu_r;
          cpu_do_r  <= PSG_DO;
        end
        default: begin
          state_r   <= ST_IDLE;
          bdir_r    <= 1'b0;
          bc_r      <= 1'b0;
          psg_di_r  <= 8'h00;
          cpu_ack_r <= 1'b0;
        end
      endcase
    end
  end

  assign CPU_ACK    = cpu_ack_r;
  assign CPU_DO     = cpu_do_r;
  assign PSG_BDIR   = bdir_r;
  assign PSG_BC     = bc_r;
  assign PSG_DI     = psg_di_r;
  assign BUSY       = (state_r != ST_IDLE);
  assign FIFO_LEVEL = level_r;
  assign PLY_READY  = (level_r != DEPTH_L);

endmodule

// File: tb/tb_psg_bus_scheduler.sv
// Directed bench for psg_bus_scheduler: CPU write/read with and without latch,
// FIFO fill and drain, simultaneous push/pop, and reset mid-transaction.
module tb_psg_bus_scheduler;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CPU_REQ = 1'b0;
  logic       CPU_WR = 1'b0;
  logic [3:0] CPU_ADDR = 4'h0;
  logic [7:0] CPU_DI = 8'h00;
  logic       CPU_ACK;
  logic [7:0] CPU_DO;
  logic       PLY_VALID = 1'b0;
  logic       PLY_READY;
  logic [3:0] PLY_ADDR = 4'h0;
  logic [7:0] PLY_DATA = 8'h00;
  logic       PSG_BDIR;
  logic       PSG_BC;
  logic [7:0] PSG_DI;
  logic [7:0] PSG_DO = 8'h00;
  logic       BUSY;
  logic [4:0] FIFO_LEVEL;

  int total = 0;
  int bad = 0;

  psg_bus_scheduler #(.FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CPU_REQ(CPU_REQ), .CPU_WR(CPU_WR), .CPU_ADDR(CPU_ADDR), .CPU_DI(CPU_DI),
    .CPU_ACK(CPU_ACK), .CPU_DO(CPU_DO),
    .PLY_VALID(PLY_VALID), .PLY_READY(PLY_READY), .PLY_ADDR(PLY_ADDR), .PLY_DATA(PLY_DATA),
    .PSG_BDIR(PSG_BDIR), .PSG_BC(PSG_BC), .PSG_DI(PSG_DI), .PSG_DO(PSG_DO),
    .BUSY(BUSY), .FIFO_LEVEL(FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic bdir, input logic bc, input logic [7:0] di);
    chk({tag, "_bdir"}, {7'd0, PSG_BDIR}, {7'd0, bdir});
    chk({tag, "_bc"}, {7'd0, PSG_BC}, {7'd0, bc});
    chk({tag, "_di"}, PSG_DI, di);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    PLY_VALID = 1'b1;
    PLY_ADDR  = a;
    PLY_DATA  = d;
  endtask

  task automatic cpu(input logic wr, input logic [3:0] a, input logic [7:0] d);
    CPU_REQ  = 1'b1;
    CPU_WR   = wr;
    CPU_ADDR = a;
    CPU_DI   = d;
  endtask

  initial begin
    tick();
    tick();
    bus("rst", 1'b0, 1'b0, 8'h00);
    chk("rst_ack", {7'd0, CPU_ACK}, 8'd0);
    chk("rst_do", CPU_DO, 8'h00);
    chk("rst_lvl", {3'd0, FIFO_LEVEL}, 8'd0);
    chk("rst_busy", {7'd0, BUSY}, 8'd0);
    chk("rst_rdy", {7'd0, PLY_READY}, 8'd1);
    RESET_N = 1'b1;
    tick();

    // first write to register 7 needs a latch phase
    cpu(1'b1, 4'd7, 8'h38);
    tick();
    bus("w1_latch", 1'b1, 1'b1, 8'h07);
    chk("w1_busy", {7'd0, BUSY}, 8'd1);
    tick();
    bus("w1_write", 1'b1, 1'b0, 8'h38);
    chk("w1_noack", {7'd0, CPU_ACK}, 8'd0);
    tick();
    bus("w1_idle", 1'b0, 1'b0, 8'h00);
    chk("w1_ack", {7'd0, CPU_ACK}, 8'd1);
    tick();
    chk("w1_ackpulse", {7'd0, CPU_ACK}, 8'd0);
    chk("w1_nogrant_on_ack", {7'd0, BUSY}, 8'd0);
    CPU_REQ = 1'b0;
    tick();

    // same register again: straight to the data phase
    cpu(1'b1, 4'd7, 8'h3F);
    tick();
    bus("w2_write", 1'b1, 1'b0, 8'h3F);
    tick();
    chk("w2_ack", {7'd0, CPU_ACK}, 8'd1);
    CPU_REQ = 1'b0;
    tick();

    // read of register 14
    cpu(1'b0, 4'd14, 8'h00);
    PSG_DO = 8'hA5;
    tick();
    bus("rd_latch", 1'b1, 1'b1, 8'h0E);
    tick();
    bus("rd_read", 1'b0, 1'b1, 8'h00);
    tick();
    chk("rd_ack", {7'd0, CPU_ACK}, 8'd1);
    chk("rd_do", CPU_DO, 8'hA5);
    bus("rd_idle", 1'b0, 1'b0, 8'h00);

    // fill the FIFO while a CPU write runs; full FIFO wins in the next IDLE
    CPU_REQ = 1'b0;
    PSG_DO = 8'h00;
    push(4'd0, 8'h10);
    tick();
    chk("f_lvl1", {3'd0, FIFO_LEVEL}, 8'd1);
    chk("f_idle", {7'd0, BUSY}, 8'd0);
    cpu(1'b1, 4'd5, 8'h55);
    push(4'd1, 8'h11);
    tick();
    bus("f_cpu_latch", 1'b1, 1'b1, 8'h05);
    chk("f_lvl2", {3'd0, FIFO_LEVEL}, 8'd2);
    push(4'd8, 8'h80);
    tick();
    bus("f_cpu_write", 1'b1, 1'b0, 8'h55);
    chk("f_lvl3", {3'd0, FIFO_LEVEL}, 8'd3);
    push(4'd8, 8'h81);
    tick();
    chk("f_ack", {7'd0, CPU_ACK}, 8'd1);
    chk("f_lvl4", {3'd0, FIFO_LEVEL}, 8'd4);
    chk("f_notready", {7'd0, PLY_READY}, 8'd0);
    PLY_VALID = 1'b0;
    tick();
    bus("p0_latch", 1'b1, 1'b1, 8'h00);
    chk("p0_lvl", {3'd0, FIFO_LEVEL}, 8'd3);
    chk("p0_ready", {7'd0, PLY_READY}, 8'd1);
    CPU_REQ = 1'b0;
    tick();
    bus("p0_write", 1'b1, 1'b0, 8'h10);
    tick();
    chk("p0_noack", {7'd0, CPU_ACK}, 8'd0);
    bus("p0_idle", 1'b0, 1'b0, 8'h00);
    tick();
    bus("p1_latch", 1'b1, 1'b1, 8'h01);
    chk("p1_lvl", {3'd0, FIFO_LEVEL}, 8'd2);
    tick();
    bus("p1_write", 1'b1, 1'b0, 8'h11);
    tick();

    // push coinciding with a player grant at level 2
    chk("pp_lvl_before", {3'd0, FIFO_LEVEL}, 8'd2);
    push(4'd8, 8'h82);
    tick();
    PLY_VALID = 1'b0;
    chk("pp_lvl_after", {3'd0, FIFO_LEVEL}, 8'd2);
    chk("pp_ready", {7'd0, PLY_READY}, 8'd1);
    bus("p2_latch", 1'b1, 1'b1, 8'h08);
    tick();
    bus("p2_write", 1'b1, 1'b0, 8'h80);
    tick();
    tick();
    bus("p3_nolatch_write", 1'b1, 1'b0, 8'h81);
    chk("p3_lvl", {3'd0, FIFO_LEVEL}, 8'd1);
    tick();
    tick();
    bus("p4_nolatch_write", 1'b1, 1'b0, 8'h82);
    chk("p4_lvl", {3'd0, FIFO_LEVEL}, 8'd0);
    chk("do_hold", CPU_DO, 8'hA5);
    tick();
    chk("drain_idle", {7'd0, BUSY}, 8'd0);

    // reset asserted in the middle of a write data phase
    cpu(1'b1, 4'd3, 8'h33);
    tick();
    bus("r_latch", 1'b1, 1'b1, 8'h03);
    push(4'd2, 8'h44);
    tick();
    PLY_VALID = 1'b0;
    bus("r_write", 1'b1, 1'b0, 8'h33);
    chk("r_lvl_pre", {3'd0, FIFO_LEVEL}, 8'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    bus("r_async", 1'b0, 1'b0, 8'h00);
    chk("r_lvl", {3'd0, FIFO_LEVEL}, 8'd0);
    chk("r_busy", {7'd0, BUSY}, 8'd0);
    chk("r_rdy", {7'd0, PLY_READY}, 8'd1);
    chk("r_do", CPU_DO, 8'h00);
    tick();
    chk("r_noack", {7'd0, CPU_ACK}, 8'd0);
    RESET_N = 1'b1;
    tick();
    bus("r_relatch", 1'b1, 1'b1, 8'h03);
    tick();
    bus("r_rewrite", 1'b1, 1'b0, 8'h33);
    tick();
    chk("r_ack", {7'd0, CPU_ACK}, 8'd1);
    CPU_REQ = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
